detector_paso_personas: RTL
===========================

Name: detector_paso_personas

Overview:
- Sits directly downstream of the ultrasonic trigger/echo controller.
- Schedules periodic measurement requests and captures each echo pulse width in clock cycles.
- Converts the pulse width to centimetres with a 2-stage multiply/shift pipeline.
- Runs a hysteresis/debounce presence FSM and counts people passing the sensor, one count per present→absent transition.

Parameters:
- CLOCK_FREQ, 50_000_000: system clock frequency in Hz (documentation; MULT is derived from it).
- MEAS_PERIOD, 3_000_000: cycles between measurement requests (60 ms).
- TIMEOUT, 2_000_000: maximum cycles to wait for a result after a request.
- SHIFT, 24: fixed-point shift for the distance conversion.
- MULT, 5755: round(SOUND_SPEED·2^SHIFT/(2·CLOCK_FREQ)), with SOUND_SPEED = 34300 cm/s.
- NEAR_CM, 80: a sample below this distance counts as near.
- FAR_CM, 120: a sample above this distance counts as far (FAR_CM > NEAR_CM).
- DEBOUNCE, 3: consecutive qualifying samples required to change presence.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 resets).
- meas_valid_i  in  1  one-cycle strobe: echo_count_i holds a completed echo width.
- echo_count_i  in  32  echo width in clock cycles.
- clear_i  in  1  synchronous clear of people_count_o.
- meas_req_o  out  1  one-cycle pulse to the controller's ready input.
- distance_o  out  16  last distance in cm, saturating.
- distance_valid_o  out  1  one-cycle pulse when distance_o updates.
- timeout_o  out  1  one-cycle pulse when a request expires.
- presence_o  out  1  debounced presence.
- people_count_o  out  16  people passed, saturating.

Behaviour:
- Reset (rst=0 at a clock edge):
  - all outputs are 0, scheduler is in WAIT_PERIOD with its timer at 0, presence FSM is ABSENT, debounce counters are 0, pipeline valids are cleared.
  - Reset asserted mid-measurement aborts the measurement; no distance_valid_o or timeout_o pulse follows.
- Scheduler FSM:
  - WAIT_PERIOD: timer counts up. When timer==MEAS_PERIOD-1 → REQUEST.
  - REQUEST: meas_req_o=1 for exactly this cycle; timer cleared → WAIT_RESULT.
  - WAIT_RESULT: timer counts up.
    - meas_valid_i=1 → capture echo_count_i, clear timer, → WAIT_PERIOD.
    - Else, when timer==TIMEOUT-1 → timeout_o=1 for one cycle, inject distance 16'hFFFF as the sample, → WAIT_PERIOD.
    - meas_valid_i on the same cycle as the timeout: the measurement wins and no timeout is flagged.
  - meas_valid_i outside WAIT_RESULT is ignored.
- Conversion pipeline:
  - Stage 1 registers the 45-bit product echo_count_i·MULT.
  - Stage 2 registers product>>SHIFT, saturated to 16'hFFFF if wider than 16 bits.
  - distance_o and distance_valid_o appear 2 cycles after the meas_valid_i cycle.
  - A timeout sample bypasses the pipeline: distance_o=16'hFFFF with distance_valid_o on the cycle after timeout_o.
- Presence FSM (evaluated only on distance_valid_o):
  - ABSENT:
    - distance_o < NEAR_CM increments near_cnt and clears far_cnt.
    - A sample ≥ NEAR_CM clears near_cnt.
    - When near_cnt reaches DEBOUNCE → PRESENT, presence_o=1, counters cleared.
  - PRESENT:
    - distance_o > FAR_CM increments far_cnt.
    - A sample ≤ FAR_CM clears far_cnt.
    - When far_cnt reaches DEBOUNCE → ABSENT, presence_o=0, and people_count_o increments on that same edge.
  - Exactly NEAR_CM is not near. Exactly FAR_CM is not far.
- people_count_o:
  - Saturates at 16'hFFFF; it does not wrap.
  - clear_i=1 forces 0 and has priority over a simultaneous increment.
  - clear_i does not affect presence_o or the debounce counters.

Test Plan:
- Reset/idle (MEAS_PERIOD=100, TIMEOUT=50): hold rst=0 for 5 cycles, then release → all outputs 0; first meas_req_o pulse exactly 100 cycles after release, width 1.
- Conversion: after a request, drive meas_valid_i with echo_count_i=291545 → distance_o=100 with distance_valid_o exactly 2 cycles later.
- Saturation and zero:
  - echo_count_i=32'hFFFFFFFF → distance_o=16'hFFFF.
  - echo_count_i=0 → distance_o=0.
- Timeout: no meas_valid_i for 50 cycles after a request → timeout_o pulses once; next cycle distance_o=16'hFFFF; next meas_req_o 100 cycles after the timeout.
- Counting (DEBOUNCE=3, NEAR_CM=80, FAR_CM=120):
  - Samples 50, 50, 100, 50, 50, 50 → presence_o rises only after the 6th sample.
  - Then 200, 120, 200, 200, 200 → presence_o falls after the last sample and people_count_o goes 0→1.
- Clear priority and stray strobe:
  - clear_i=1 on the same cycle as a count increment → people_count_o=0.
  - meas_valid_i during WAIT_PERIOD → no distance_valid_o.

Source files
------------

// File: rtl/detector_paso_personas.sv
// People counter behind an ultrasonic trigger/echo controller: schedules measurement requests,
// converts echo width to centimetres and debounces presence to count passers-by.
module detector_paso_personas #(
  parameter int unsigned CLOCK_FREQ  = 50_000_000,
  parameter int unsigned MEAS_PERIOD = 3_000_000,
  parameter int unsigned TIMEOUT     = 2_000_000,
  parameter int unsigned SHIFT       = 24,
  parameter int unsigned MULT        =
    32'(((64'd34300 << SHIFT) + 64'(CLOCK_FREQ)) / (64'd2 * 64'(CLOCK_FREQ))),
  parameter int unsigned NEAR_CM     = 80,
  parameter int unsigned FAR_CM      = 120,
  parameter int unsigned DEBOUNCE    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        meas_valid_i,
  input  logic [31:0] echo_count_i,
  input  logic        clear_i,
  output logic        meas_req_o,
  output logic [15:0] distance_o,
  output logic        distance_valid_o,
  output logic        timeout_o,
  output logic        presence_o,
  output logic [15:0] people_count_o
);

  localparam int unsigned CW     = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DEB  = CW'(DEBOUNCE);
  localparam logic [12:0] MULT_W = 13'(MULT);
  localparam logic [15:0] NEAR_W = 16'(NEAR_CM);
  localparam logic [15:0] FAR_W  = 16'(FAR_CM);

  typedef enum logic [1:0] {S_WAIT_PERIOD, S_REQUEST, S_WAIT_RESULT} sched_e;
  typedef enum logic {P_ABSENT, P_PRESENT} pres_e;

  sched_e        sched_q;
  logic [31:0]   timer_q;
  logic          req_q, to_q;
  logic          s1_valid_q;
  logic [44:0]   prod_q;
  logic [44:0]   scaled_d;
  logic          capture_d;
  logic [15:0]   dist_q;
  logic          dv_q;
  pres_e         pres_q;
  logic          presence_q;
  logic [CW-1:0] near_q, far_q, near_d, far_d;
  logic          is_near_d, is_far_d, leave_d;
  logic [15:0]   count_q;

  assign capture_d = (sched_q == S_WAIT_RESULT) && meas_valid_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sched_q <= S_WAIT_PERIOD;
      timer_q <= '0;
      req_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      req_q <= 1'b0;
      to_q  <= 1'b0;
      unique case (sched_q)
        S_WAIT_PERIOD: begin
          if (timer_q == MEAS_PERIOD - 1) begin
            sched_q <= S_REQUEST;
            req_q   <= 1'b1;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        S_REQUEST: begin
          timer_q <= '0;
          sched_q <= S_WAIT_RESULT;
        end
        S_WAIT_RESULT: begin
          // a result arriving on the expiry cycle takes precedence over the timeout
          if (meas_valid_i) begin
            timer_q <= '0;
            sched_q <= S_WAIT_PERIOD;
          end else if (timer_q == TIMEOUT - 1) begin
            to_q    <= 1'b1;
            timer_q <= '0;
            sched_q <= S_WAIT_PERIOD;
          end else begin
            timer_q <= timer_q + 32'd1;
          end
        end
        default: sched_q <= S_WAIT_PERIOD;
      endcase
    end
  end

  assign scaled_d = prod_q >> SHIFT;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      prod_q     <= '0;
      dist_q     <= '0;
      dv_q       <= 1'b0;
    end else begin
      s1_valid_q <= capture_d;
      if (capture_d) prod_q <= 45'(echo_count_i) * 45'(MULT_W);
      dv_q <= s1_valid_q | to_q;
      if (s1_valid_q) dist_q <= (|scaled_d[44:16]) ? 16'hFFFF : scaled_d[15:0];
      else if (to_q) dist_q <= '1;
    end
  end

  assign near_d    = near_q + CW'(1);
  assign far_d     = far_q + CW'(1);
  assign is_near_d = dist_q < NEAR_W;
  assign is_far_d  = dist_q > FAR_W;
  assign leave_d   = dv_q && (pres_q == P_PRESENT) && is_far_d && (far_d == DEB);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pres_q     <= P_ABSENT;
      presence_q <= 1'b0;
      near_q     <= '0;
      far_q      <= '0;
      count_q    <= '0;
    end else begin
      if (dv_q) begin
        unique case (pres_q)
          P_ABSENT: begin
            if (is_near_d) begin
              far_q <= '0;
              if (near_d == DEB) begin
                pres_q     <= P_PRESENT;
                presence_q <= 1'b1;
                near_q     <= '0;
              end else begin
                near_q <= near_d;
              end
            end else begin
              near_q <= '0;
            end
          end
          P_PRESENT: begin
            if (is_far_d) begin
              if (far_d == DEB) begin
                pres_q     <= P_ABSENT;
                presence_q <= 1'b0;
                far_q      <= '0;
                near_q     <= '0;
              end else begin
                far_q <= far_d;
              end
            end else begin
              far_q <= '0;
            end
          end
          default: pres_q <= P_ABSENT;
        endcase
      end
      if (clear_i) count_q <= '0;
      else if (leave_d && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
    end
  end

  assign meas_req_o       = req_q;
  assign timeout_o        = to_q;
  assign distance_o       = dist_q;
  assign distance_valid_o = dv_q;
  assign presence_o       = presence_q;
  assign people_count_o   = count_q;

endmodule
